// File: rtl/bf_core_pipe.sv
// Multi-cycle Brainfuck execution core: hardware loop stack, stream IO handshakes, sync-read RAM.
// Optional single-step debug (step_i, pc_dbg_o) is built when BF_STEP_EN is defined.
module bf_core_pipe #(
    parameter int unsigned RAM_ADDR_W = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ROM_ADDR_W = 10,
    parameter int unsigned LOOP_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  start_i,
`ifdef BF_STEP_EN
    input  logic                  step_i,
    output logic [ROM_ADDR_W-1:0] pc_dbg_o,
`endif
    input  logic [ROM_ADDR_W-1:0] prog_len_i,
    output logic [ROM_ADDR_W-1:0] rom_addr_o,
    input  logic [2:0]            rom_opcode_i,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [DATA_W-1:0]     ram_wdata_o,
    input  logic [DATA_W-1:0]     ram_rdata_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W-1:0]     out_data_o,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     in_data_i,
    output logic                  busy_o,
    output logic                  halted_o,
    output logic                  error_o,
    output logic [1:0]            err_code_o
);

    localparam int unsigned SpW   = $clog2(LOOP_DEPTH + 1);
    localparam int unsigned NestW = ROM_ADDR_W + 1;

    localparam logic [ROM_ADDR_W-1:0] PcOne   = ROM_ADDR_W'(1);
    localparam logic [RAM_ADDR_W-1:0] DpOne   = RAM_ADDR_W'(1);
    localparam logic [DATA_W-1:0]     CellOne = DATA_W'(1);
    localparam logic [SpW-1:0]        SpOne   = SpW'(1);
    localparam logic [SpW-1:0]        SpMax   = SpW'(LOOP_DEPTH);
    localparam logic [NestW-1:0]      NestOne = NestW'(1);

    localparam logic [1:0] ErrNone = 2'd0;
    localparam logic [1:0] ErrOvf  = 2'd1;
    localparam logic [1:0] ErrUnf  = 2'd2;
    localparam logic [1:0] ErrUnm  = 2'd3;

    typedef enum logic [2:0] {
        StIdle, StLoad, StExec, StSkip, StOutW, StInW, StHalt, StError
    } state_e;

    state_e                  state_q, state_d;
    logic [ROM_ADDR_W-1:0]   pc_q, pc_d;
    logic [RAM_ADDR_W-1:0]   dp_q, dp_d;
    logic [SpW-1:0]          sp_q, sp_d;
    logic [NestW-1:0]        nest_q, nest_d;
    logic [DATA_W-1:0]       cell_q, cell_d;
    logic [1:0]              err_q, err_d;
    logic [ROM_ADDR_W-1:0]   stack_q [2**SpW];
    logic                    push;
    logic                    step_ok;
    logic                    adv;

`ifdef BF_STEP_EN
    assign step_ok  = step_i;
    assign pc_dbg_o = pc_q;
`else
    assign step_ok  = 1'b1;
`endif

    // Handshake states ignore step; only the fetch/execute states are gated by it.
    assign adv = enable_i & step_ok;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        dp_d     = dp_q;
        sp_d     = sp_q;
        nest_d   = nest_q;
        cell_d   = cell_q;
        err_d    = err_q;
        ram_we_o = 1'b0;
        push     = 1'b0;
        unique case (state_q)
            StIdle, StHalt, StError: begin
                if (enable_i && start_i) begin
                    state_d = StLoad;
                    pc_d    = '0;
                    dp_d    = '0;
                    sp_d    = '0;
                    err_d   = ErrNone;
                end
            end
            StLoad: begin
                if (adv) begin
                    cell_d  = ram_rdata_i;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (adv) begin
                    if (pc_q == prog_len_i) begin
                        state_d = StHalt;
                    end else begin
                        unique case (rom_opcode_i)
                            3'b111: begin
                                cell_d   = cell_q + CellOne;
                                ram_we_o = 1'b1;
                                pc_d     = pc_q + PcOne;
                            end
                            3'b110: begin
                                cell_d   = cell_q - CellOne;
                                ram_we_o = 1'b1;
                                pc_d     = pc_q + PcOne;
                            end
                            3'b101: begin
                                dp_d    = dp_q + DpOne;
                                pc_d    = pc_q + PcOne;
                                state_d = StLoad;
                            end
                            3'b100: begin
                                dp_d    = dp_q - DpOne;
                                pc_d    = pc_q + PcOne;
                                state_d = StLoad;
                            end
                            3'b011: begin
                                if (cell_q == '0) begin
                                    nest_d  = '0;
                                    pc_d    = pc_q + PcOne;
                                    state_d = StSkip;
                                end else if (sp_q == SpMax) begin
                                    err_d   = ErrOvf;
                                    state_d = StError;
                                end else begin
                                    push = 1'b1;
                                    sp_d = sp_q + SpOne;
                                    pc_d = pc_q + PcOne;
                                end
                            end
                            3'b010: begin
                                if (sp_q == '0) begin
                                    err_d   = ErrUnf;
                                    state_d = StError;
                                end else if (cell_q != '0) begin
                                    pc_d = stack_q[sp_q - SpOne] + PcOne;
                                end else begin
                                    sp_d = sp_q - SpOne;
                                    pc_d = pc_q + PcOne;
                                end
                            end
                            3'b001: state_d = StOutW;
                            3'b000: state_d = StInW;
                            default: ;
                        endcase
                    end
                end
            end
            StSkip: begin
                if (adv) begin
                    if (pc_q == prog_len_i) begin
                        err_d   = ErrUnm;
                        state_d = StError;
                    end else begin
                        pc_d = pc_q + PcOne;
                        if (rom_opcode_i == 3'b011) begin
                            nest_d = nest_q + NestOne;
                        end else if (rom_opcode_i == 3'b010) begin
                            if (nest_q == '0) begin
                                state_d = StExec;
                            end else begin
                                nest_d = nest_q - NestOne;
                            end
                        end
                    end
                end
            end
            StOutW: begin
                if (enable_i && out_ready_i) begin
                    pc_d    = pc_q + PcOne;
                    state_d = StExec;
                end
            end
            StInW: begin
                if (enable_i && in_valid_i) begin
                    cell_d   = in_data_i;
                    ram_we_o = 1'b1;
                    pc_d     = pc_q + PcOne;
                    state_d  = StExec;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            pc_q    <= '0;
            dp_q    <= '0;
            sp_q    <= '0;
            nest_q  <= '0;
            cell_q  <= '0;
            err_q   <= ErrNone;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            dp_q    <= dp_d;
            sp_q    <= sp_d;
            nest_q  <= nest_d;
            cell_q  <= cell_d;
            err_q   <= err_d;
        end
    end

    // Loop stack contents are don't-care after reset; only sp is cleared.
    always_ff @(posedge clk_i) begin
        if (push) begin
            stack_q[sp_q] <= pc_q;
        end
    end

    // RAM sees the next pointer so its registered read data is ready during LOAD.
    assign ram_addr_o  = dp_d;
    assign ram_wdata_o = cell_d;
    assign rom_addr_o  = pc_q;
    assign out_valid_o = (state_q == StOutW);
    assign out_data_o  = cell_q;
    assign in_ready_o  = (state_q == StInW);
    assign busy_o      = !(state_q inside {StIdle, StHalt, StError});
    assign halted_o    = (state_q == StHalt);
    assign error_o     = (state_q == StError);
    assign err_code_o  = err_q;

endmodule

// File: tb/tb_bf_core_pipe.sv
// Scoreboard bench for bf_core_pipe: directed programs, output beats checked by a monitor.
module tb_bf_core_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       start = 1'b0;
    logic [9:0] prog_len = '0;
    logic [9:0] rom_addr;
    logic [2:0] rom_opcode;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       busy, halted, error;
    logic [1:0] err_code;

    logic [2:0] rom [1024];
    logic [7:0] mem [256];
    logic       clr_req = 1'b0;
    int         we_cnt = 0;
    int         rdy_stall = 0;
    int         in_wait = 0;
    logic       in_pend = 1'b0;
    logic [7:0] in_byte = '0;
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         failures = 0;
    bit         done;

    always #5 clk = ~clk;

    bf_core_pipe #(
        .RAM_ADDR_W(8), .DATA_W(8), .ROM_ADDR_W(10), .LOOP_DEPTH(2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .start_i     (start),
        .prog_len_i  (prog_len),
        .rom_addr_o  (rom_addr),
        .rom_opcode_i(rom_opcode),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .busy_o      (busy),
        .halted_o    (halted),
        .error_o     (error),
        .err_code_o  (err_code)
    );

    assign rom_opcode = rom[rom_addr];

    // Synchronous-read RAM with one-cycle latency
    always @(posedge clk) begin
        if (clr_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            we_cnt <= 0;
        end else begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                we_cnt <= we_cnt + 1;
            end
        end
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (out_valid && rdy_stall > 0) begin
                out_ready = 1'b0;
                rdy_stall = rdy_stall - 1;
            end else begin
                out_ready = 1'b1;
            end
            if (in_ready && in_pend) begin
                if (in_wait > 0) begin
                    in_wait = in_wait - 1;
                    in_valid = 1'b0;
                end else begin
                    in_valid = 1'b1;
                    in_data = in_byte;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    // Output monitor: compares every presented beat against the scoreboard head
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                if (out_ready) begin
                    checks = checks + 1;
                    failures = failures + 1;
                    $display("FAIL out_beat: got data %0h, no beat required", out_data);
                end
            end else begin
                checks = checks + 1;
                if (out_data !== exp_q[0]) begin
                    failures = failures + 1;
                    $display("FAIL out_data: got %0h required %0h", out_data, exp_q[0]);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic load_prog(input string p);
        for (int i = 0; i < 1024; i++) rom[i] = 3'b000;
        for (int i = 0; i < p.len(); i++) begin
            case (p[i])
                "+": rom[i] = 3'b111;
                "-": rom[i] = 3'b110;
                ">": rom[i] = 3'b101;
                "<": rom[i] = 3'b100;
                "[": rom[i] = 3'b011;
                "]": rom[i] = 3'b010;
                ".": rom[i] = 3'b001;
                default: rom[i] = 3'b000;
            endcase
        end
        prog_len = 10'(p.len());
    endtask

    task automatic clear_ram();
        clr_req = 1'b1;
        @(posedge clk);
        #1 clr_req = 1'b0;
    endtask

    task automatic run(input string nm, input int budget, output bit ok);
        ok = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (halted || error) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL %s_timeout: got no halt/error required one within %0d cycles", nm, budget);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);

        // "+++." -> one beat 0x03
        clear_ram();
        load_prog("+++.");
        exp_q.push_back(8'h03);
        run("p1", 200, done);
        chk("p1_halted", 32'(halted), 1);
        chk("p1_error", 32'(error), 0);
        chk("p1_ram0", 32'(mem[0]), 3);
        chk("p1_beats_left", 32'(exp_q.size()), 0);

        // Simple loop moving cell 0 into cell 1
        clear_ram();
        load_prog("++[->+<]>.");
        exp_q.push_back(8'h02);
        run("p2", 300, done);
        chk("p2_halted", 32'(halted), 1);
        chk("p2_ram0", 32'(mem[0]), 0);
        chk("p2_ram1", 32'(mem[1]), 2);
        chk("p2_beats_left", 32'(exp_q.size()), 0);

        // Nested skip: body never executes
        clear_ram();
        load_prog("[[+]+].");
        exp_q.push_back(8'h00);
        run("p3", 200, done);
        chk("p3_halted", 32'(halted), 1);
        chk("p3_we_count", 32'(we_cnt), 0);
        chk("p3_beats_left", 32'(exp_q.size()), 0);

        // Error paths
        clear_ram();
        load_prog("+[[[");
        run("e1", 200, done);
        chk("e1_error", 32'(error), 1);
        chk("e1_halted", 32'(halted), 0);
        chk("e1_code", 32'(err_code), 1);
        load_prog("]");
        run("e2", 200, done);
        chk("e2_error", 32'(error), 1);
        chk("e2_code", 32'(err_code), 2);
        clear_ram();
        load_prog("[");
        run("e3", 200, done);
        chk("e3_error", 32'(error), 1);
        chk("e3_code", 32'(err_code), 3);

        // Delayed input then back-pressured output
        clear_ram();
        load_prog(",.");
        in_byte = 8'h41;
        in_wait = 5;
        in_pend = 1'b1;
        rdy_stall = 3;
        exp_q.push_back(8'h41);
        run("io", 300, done);
        in_pend = 1'b0;
        chk("io_halted", 32'(halted), 1);
        chk("io_error", 32'(error), 0);
        chk("io_ram0", 32'(mem[0]), 8'h41);
        chk("io_beats_left", 32'(exp_q.size()), 0);
        chk("io_stall_used", 32'(rdy_stall), 0);

        // Async reset in the middle of a loop, then rerun
        clear_ram();
        load_prog("++++++[-]+.");
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #1 chk("mid_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_halted", 32'(halted), 0);
        chk("arst_error", 32'(error), 0);
        chk("arst_ram_we", 32'(ram_we), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        chk("arst_rom_addr", 32'(rom_addr), 0);
        chk("arst_ram_addr", 32'(ram_addr), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_ram();
        exp_q.push_back(8'h01);
        run("rerun", 300, done);
        chk("rerun_halted", 32'(halted), 1);
        chk("rerun_ram0", 32'(mem[0]), 1);
        chk("rerun_beats_left", 32'(exp_q.size()), 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bf_core_pipe.md
Name: bf_core_pipe

Overview:
- Parametrised successor to the BF execution core: multi-cycle FSM that fetches 3-bit Brainfuck opcodes from program ROM and executes them against data RAM.
- Adds a LOOP_DEPTH hardware loop stack with overflow/underflow detection, and an explicit program-length halt.
- Adds valid/ready stream handshakes for '.' and ',', and synchronous-read RAM support.
- Sits between program ROM, cell RAM and the UART/IO stream adapters.

Parameters:
- RAM_ADDR_W, 8, data pointer / RAM address width
- DATA_W, 8, cell width
- ROM_ADDR_W, 10, program counter width
- LOOP_DEPTH, 8, loop stack entries (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  0 = freeze all state; ram_we forced 0
- start  in  1  pulse; begins execution from IDLE or HALT
- prog_len  in  ROM_ADDR_W  number of valid opcodes; pc==prog_len means end
- rom_addr  out  ROM_ADDR_W  = pc
- rom_opcode  in  3  combinational ROM data for rom_addr
- ram_addr  out  RAM_ADDR_W  = dp
- ram_we  out  1  write strobe
- ram_wdata  out  DATA_W  write data
- ram_rdata  in  DATA_W  read data, 1-cycle latency after ram_addr
- out_valid / out_ready / out_data  out / in / out  1 / 1 / DATA_W  output stream
- in_valid / in_ready / in_data  in / out / in  1 / 1 / DATA_W  input stream
- busy  out  1  state not IDLE/HALT/ERROR
- halted  out  1  state==HALT
- error  out  1  state==ERROR
- err_code  out  2  0 none, 1 stack overflow, 2 stack underflow, 3 unmatched '['

Behaviour:
- Encoding: 111 '+', 110 '-', 101 '>', 100 '<', 011 '[', 010 ']', 001 '.', 000 ','.
- Reset (async): state IDLE; pc, dp, sp, nest, cell cleared; all strobes/valids/flags 0; err_code 0.
- States:
  - IDLE: start -> LOAD, pc=0, dp=0, sp=0.
  - LOAD: capture ram_rdata into cell -> EXEC.
  - EXEC: decode rom_opcode; if pc==prog_len -> HALT.
  - SKIP: scan forward for matching ']'.
  - OUT_W, IN_W: stream handshakes.
  - HALT / ERROR: sticky until start (which restarts as from IDLE and clears err_code) or rst.
- EXEC timing, 1 cycle each unless noted:
  - '+' / '-': cell += / -= 1, modulo 2^DATA_W; ram_we=1 with new value same cycle; pc+1.
  - '>' / '<': dp +/- 1, wrapping modulo 2^RAM_ADDR_W; pc+1 -> LOAD. Total 2 cycles.
  - '[' with cell!=0: sp==LOOP_DEPTH -> ERROR, code 1. Else push pc; pc+1.
  - '[' with cell==0: nest=0; pc+1 -> SKIP.
  - ']' with sp==0: ERROR, code 2.
  - ']' with cell!=0: pc = stack[sp-1]+1; no pop.
  - ']' with cell==0: pop; pc+1.
  - '.': -> OUT_W; out_valid=1, out_data=cell, held stable until out_ready. Transfer cycle: pc+1 -> EXEC.
  - ',': -> IN_W; in_ready=1. On in_valid&&in_ready: cell=in_data, ram_we=1, pc+1 -> EXEC.
- SKIP, one opcode per cycle:
  - '[': nest+1.
  - ']': if nest==0 -> EXEC; else nest-1.
  - Always pc+1.
  - pc==prog_len in SKIP -> ERROR, code 3.
  - nest width is clog2(ROM_DEPTH)+1; no overflow.
- Stack holds ROM_ADDR_W-bit entries and is not cleared on reset; sp is cleared.
- enable low mid-handshake: out_valid/in_ready held at current value, but no transfer completes and no state advances.

Optional Feature:
- BF_STEP_EN
  - Defined: adds input step (1 bit). EXEC, SKIP and LOAD advance only on cycles with step=1; handshake states are unaffected. Adds output pc_dbg (ROM_ADDR_W) = pc.
  - Undefined: step and pc_dbg are absent; core free-runs.

Test Plan:
- Program "+++." prog_len=4, out_ready=1 -> one out_valid beat with data 0x03, then halted=1; RAM[0]=3.
- "++[->+<]>." -> out_data 0x02; RAM[0]=0, RAM[1]=2; sp=0 at HALT.
- "[[+]+]." with RAM[0]=0 -> nested skip; out_data 0x00; '+' never executed, ram_we never asserted.
- LOOP_DEPTH=2, "+[[[" -> error=1, err_code=1 at third '['. Program "]" -> err_code=2. Program "[" with cell 0 -> err_code=3.
- "," with in_valid delayed 5 cycles (in_data 0x41) then "." with out_ready low 3 cycles -> out_data held 0x41 stable, one transfer only.
- rst asserted mid-loop -> next edge-independent: state IDLE, all outputs 0; start reruns the program correctly.
